// File: rtl/adder_arbiter_pkg.sv
// Shared types, defaults and the round-robin search helper for adder_arbiter.
package adder_arbiter_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} add_op_e;

  typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_state_e;

  // Round-robin one-hot search over up to 8 requesters: the first set bit of
  // req at or above ptr, wrapping at n. Callers truncate the result to n bits.
  function automatic logic [7:0] rr_onehot(input logic [7:0] req,
                                           input logic [2:0] ptr,
                                           input logic [3:0] n);
    logic [7:0] grant;
    logic       found;
    logic       hit;
    logic [3:0] raw;
    logic [3:0] idx;
    grant = 8'd0;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      raw   = {1'b0, ptr} + k[3:0];
      idx   = (raw >= n) ? (raw - n) : raw;
      hit   = (k[3:0] < n) && !found && req[idx[2:0]];
      grant[idx[2:0]] = grant[idx[2:0]] | hit;
      found = found | hit;
    end
    return grant;
  endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// Request/response bus of the shared adder. Optional flag outputs are present
// only when ADDER_ARBITER_FLAGS_EN is defined.
interface adder_arbiter_if
  import adder_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ID_W    = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0]        req_sub;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [DATA_W-1:0]         resp_data;
  logic [ID_W-1:0]           resp_id;

`ifdef ADDER_ARBITER_FLAGS_EN
  logic                      resp_carry;
  logic                      resp_ovf;

  modport master (
    output req_valid, req_a, req_b, req_sub, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id, resp_carry, resp_ovf
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sub, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id, resp_carry, resp_ovf
  );
`else
  modport master (
    output req_valid, req_a, req_b, req_sub, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sub, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id
  );
`endif

endinterface

// File: rtl/adder_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// after ptr (with wrap-around) as one-hot plus binary index.
module rr_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any_grant
);

  logic [N-1:0]  grant_s;
  logic [PW-1:0] idx_s;

  // One-hot search starting at the pointer.
  always_comb begin
    grant_s = N'(rr_onehot(8'(req), 3'(ptr), 4'(N)));
  end

  // Encode the one-hot grant into a binary index (zero when nothing granted).
  always_comb begin
    idx_s = {PW{1'b0}};
    for (int i = 0; i < N; i++) begin
      idx_s = idx_s | ({PW{grant_s[i]}} & PW'(i));
    end
  end

  assign grant     = grant_s;
  assign grant_idx = idx_s;
  assign any_grant = |grant_s;

endmodule

// File: rtl/adder_arbiter.sv
// Shared 32-bit adder/subtractor with round-robin arbitration over NUM_REQ
// requesters and a single registered, ID-tagged response slot.
// Optional carry/overflow flags: define ADDER_ARBITER_FLAGS_EN.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input logic             clk,
  input logic             rst,
  adder_arbiter_if.slave  bus
);

  slot_state_e       state_r;
  slot_state_e       state_next_s;
  logic [ID_W-1:0]   rr_ptr_r;
  logic [ID_W-1:0]   rr_ptr_next_s;
  logic              slot_free_s;
  logic [NUM_REQ-1:0] arb_req_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [ID_W-1:0]   grant_idx_s;
  logic              xfer_s;
  logic [DATA_W-1:0] op_a_s;
  logic [DATA_W-1:0] op_b_s;
  logic [DATA_W-1:0] b_eff_s;
  logic              sub_s;
  add_op_e           op_s;
  logic [DATA_W-1:0] sum_s;
  logic [DATA_W-1:0] resp_data_r;
  logic [ID_W-1:0]   resp_id_r;

  // A new result may be accepted when the slot is empty or is being drained.
  assign slot_free_s = (state_r == SLOT_EMPTY) || bus.resp_ready;

  // Hide all requests from the arbiter during reset or while the slot is blocked.
  always_comb begin
    arb_req_s = {NUM_REQ{1'b0}};
    if (rst || !slot_free_s) begin
      arb_req_s = {NUM_REQ{1'b0}};
    end else begin
      arb_req_s = bus.req_valid;
    end
  end

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (ID_W)
  ) u_rr_arbiter (
    .req       (arb_req_s),
    .ptr       (rr_ptr_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .any_grant (xfer_s)
  );

  assign bus.req_ready = grant_s;

  // Select the granted requester's operands and form the two's-complement B.
  always_comb begin
    op_a_s  = bus.req_a[int'(grant_idx_s)*DATA_W +: DATA_W];
    op_b_s  = bus.req_b[int'(grant_idx_s)*DATA_W +: DATA_W];
    op_s    = add_op_e'(bus.req_sub[grant_idx_s]);
    sub_s   = (op_s == OP_SUB);
    b_eff_s = sub_s ? ~op_b_s : op_b_s;
  end

`ifdef ADDER_ARBITER_FLAGS_EN
  logic [DATA_W:0] sum_ext_s;
  logic            carry_s;
  logic            ovf_s;
  logic            resp_carry_r;
  logic            resp_ovf_r;

  // Adder with carry-out; overflow when equal-sign inputs give a flipped sign.
  always_comb begin
    sum_ext_s = {1'b0, op_a_s} + {1'b0, b_eff_s} + {{DATA_W{1'b0}}, sub_s};
    sum_s     = sum_ext_s[DATA_W-1:0];
    carry_s   = sum_ext_s[DATA_W];
    ovf_s     = (op_a_s[DATA_W-1] == b_eff_s[DATA_W-1]) &&
                (sum_ext_s[DATA_W-1] != op_a_s[DATA_W-1]);
  end

  // Flag registers track the response data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_carry_r <= 1'b0;
      resp_ovf_r   <= 1'b0;
    end else if (xfer_s) begin
      resp_carry_r <= carry_s;
      resp_ovf_r   <= ovf_s;
    end else begin
      resp_carry_r <= resp_carry_r;
      resp_ovf_r   <= resp_ovf_r;
    end
  end

  assign bus.resp_carry = resp_carry_r;
  assign bus.resp_ovf   = resp_ovf_r;
`else
  // Plain DATA_W-bit adder; wrap-around is silent.
  always_comb begin
    sum_s = op_a_s + b_eff_s + {{(DATA_W-1){1'b0}}, sub_s};
  end
`endif

  // Next pointer is one past the granted requester, wrapping at NUM_REQ.
  always_comb begin
    rr_ptr_next_s = rr_ptr_r;
    if (grant_idx_s == ID_W'(NUM_REQ-1)) begin
      rr_ptr_next_s = {ID_W{1'b0}};
    end else begin
      rr_ptr_next_s = grant_idx_s + ID_W'(1);
    end
  end

  // Round-robin pointer advances only on a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r <= {ID_W{1'b0}};
    end else if (xfer_s) begin
      rr_ptr_r <= rr_ptr_next_s;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Response slot next-state: fill on transfer, empty when drained without refill.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      SLOT_EMPTY: begin
        if (xfer_s) begin
          state_next_s = SLOT_FULL;
        end else begin
          state_next_s = SLOT_EMPTY;
        end
      end
      SLOT_FULL: begin
        if (xfer_s) begin
          state_next_s = SLOT_FULL;
        end else if (bus.resp_ready) begin
          state_next_s = SLOT_EMPTY;
        end else begin
          state_next_s = SLOT_FULL;
        end
      end
      default: begin
        state_next_s = SLOT_EMPTY;
      end
    endcase
  end

  // Response slot state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= SLOT_EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Response data/id load on transfer and otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_data_r <= {DATA_W{1'b0}};
      resp_id_r   <= {ID_W{1'b0}};
    end else if (xfer_s) begin
      resp_data_r <= sum_s;
      resp_id_r   <= grant_idx_s;
    end else begin
      resp_data_r <= resp_data_r;
      resp_id_r   <= resp_id_r;
    end
  end

  assign bus.resp_valid = (state_r == SLOT_FULL);
  assign bus.resp_data  = resp_data_r;
  assign bus.resp_id    = resp_id_r;

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: directed stimulus pushes hand-computed
// responses; a negedge monitor pops and compares each accepted response.
module tb_adder_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  id;
    logic        carry;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  adder_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW), .ID_W(IW)) bus ();

  adder_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ID_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [1:0] id,
                          input logic c, input logic o);
    exp_t e;
    e.data = d; e.id = id; e.carry = c; e.ovf = o;
    exp_q.push_back(e);
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic sub);
    bus.req_valid[i]       = v;
    bus.req_a[i*DW +: DW]  = a;
    bus.req_b[i*DW +: DW]  = b;
    bus.req_sub[i]         = sub;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every response accepted by the consumer must match the queue head.
  always @(negedge clk) begin
    if (!rst && bus.resp_valid && bus.resp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected actual=%h/%0d required=none", bus.resp_data, bus.resp_id);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_data", bus.resp_data, mon_e.data);
        check("resp_id", 32'(bus.resp_id), 32'(mon_e.id));
`ifdef ADDER_ARBITER_FLAGS_EN
        check("resp_carry", 32'(bus.resp_carry), 32'(mon_e.carry));
        check("resp_ovf", 32'(bus.resp_ovf), 32'(mon_e.ovf));
`endif
      end
    end
  end

  initial begin
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_sub    = '0;
    bus.resp_ready = 1'b1;
    rst            = 1'b1;

    // Reset state, with requests asserted during reset.
    repeat (2) step();
    bus.req_valid = 4'hF;
    @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'h0);
    check("rst_valid", 32'(bus.resp_valid), 32'h0);
    check("rst_data", bus.resp_data, 32'h0);
    check("rst_id", 32'(bus.resp_id), 32'h0);
    step();
    rst = 1'b0;
    bus.req_valid = 4'h0;

    // Single request from requester 2.
    set_req(2, 1'b1, 32'h0000_0010, 32'h0000_0004, 1'b0);
    push_exp(32'h0000_0014, 2'd2, 1'b0, 1'b0);
    @(negedge clk);
    check("single_ready", 32'(bus.req_ready), 32'h4);
    step();
    set_req(2, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check("single_resp_valid", 32'(bus.resp_valid), 32'h1);
    step();

    // Wrap-around add, then subtract below zero (pointer is 3, only 0 valid).
    set_req(0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    push_exp(32'h0000_0000, 2'd0, 1'b1, 1'b0);
    @(negedge clk);
    check("wrap_ready", 32'(bus.req_ready), 32'h1);
    step();
    set_req(0, 1'b1, 32'h0000_0000, 32'h0000_0001, 1'b1);
    push_exp(32'hFFFF_FFFF, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("sub_ready", 32'(bus.req_ready), 32'h1);
    step();
    set_req(0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    step();

    // Signed overflow from requester 1 (pointer is 1).
    set_req(1, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    push_exp(32'h8000_0000, 2'd1, 1'b0, 1'b1);
    @(negedge clk);
    check("ovf_ready", 32'(bus.req_ready), 32'h2);
    step();
    set_req(1, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    step();

    // Fairness from reset: all four valid, grants 0,1,2,3,0,1 back to back.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < NR; i++) begin
      set_req(i, 1'b1, 32'(i * 256), 32'(i), 1'b0);
    end
    for (int k = 0; k < 6; k++) begin
      push_exp(32'((k % 4) * 257), 2'(k % 4), 1'b0, 1'b0);
      @(negedge clk);
      check("fair_ready", 32'(bus.req_ready), 32'(1 << (k % 4)));
      if (k > 0) begin
        check("fair_no_bubble", 32'(bus.resp_valid), 32'h1);
      end
      step();
    end
    bus.req_valid = 4'h0;

    // Backpressure: fill slot via requester 0, then stall with 1 and 3 valid.
    set_req(0, 1'b1, 32'h0000_1000, 32'h0000_0234, 1'b1);
    push_exp(32'h0000_0DCC, 2'd0, 1'b1, 1'b0);
    @(negedge clk);
    check("fill_ready", 32'(bus.req_ready), 32'h1);
    step();
    bus.resp_ready = 1'b0;
    set_req(0, 1'b0, 32'h0, 32'h0, 1'b0);
    set_req(1, 1'b1, 32'h0000_0005, 32'h0000_0003, 1'b1);
    set_req(3, 1'b1, 32'h0000_0020, 32'h0000_0022, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_ready", 32'(bus.req_ready), 32'h0);
      check("bp_valid", 32'(bus.resp_valid), 32'h1);
      check("bp_data", bus.resp_data, 32'h0000_0DCC);
      check("bp_id", 32'(bus.resp_id), 32'h0);
      step();
    end
    bus.resp_ready = 1'b1;
    push_exp(32'h0000_0002, 2'd1, 1'b1, 1'b0);
    @(negedge clk);
    check("bp_release_ready", 32'(bus.req_ready), 32'h2);
    step();
    set_req(1, 1'b0, 32'h0, 32'h0, 1'b0);
    push_exp(32'h0000_0042, 2'd3, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_next_ready", 32'(bus.req_ready), 32'h8);
    step();
    set_req(3, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    step();

    // Reset mid-stream: pending response is discarded, pointer returns to 0.
    bus.resp_ready = 1'b0;
    set_req(2, 1'b1, 32'h0000_0001, 32'h0000_0001, 1'b0);
    @(negedge clk);
    check("pre_rst_ready", 32'(bus.req_ready), 32'h4);
    step();
    set_req(2, 1'b0, 32'h0, 32'h0, 1'b0);
    set_req(1, 1'b1, 32'h0000_0011, 32'h0000_0022, 1'b0);
    set_req(3, 1'b1, 32'h0000_0040, 32'h0000_0001, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_pending_valid", 32'(bus.resp_valid), 32'h1);
    check("rst_cycle_ready", 32'(bus.req_ready), 32'h0);
    step();
    rst = 1'b0;
    bus.resp_ready = 1'b1;
    push_exp(32'h0000_0033, 2'd1, 1'b0, 1'b0);
    @(negedge clk);
    check("post_rst_valid", 32'(bus.resp_valid), 32'h0);
    check("post_rst_ready", 32'(bus.req_ready), 32'h2);
    step();
    set_req(1, 1'b0, 32'h0, 32'h0, 1'b0);
    push_exp(32'h0000_003F, 2'd3, 1'b1, 1'b0);
    @(negedge clk);
    check("post_rst_next_ready", 32'(bus.req_ready), 32'h8);
    step();
    set_req(3, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (4) step();

    @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one 32-bit adder/subtractor datapath among NUM_REQ requesters.
- Arbitration is round-robin, with a valid/ready handshake on each request port and one registered response channel tagged with the requester ID.
- Sits between the instruction-side and data-side address generators (branch target, PC+4, effective address) and the single shared adder resource.

Parameters:
- NUM_REQ, 4, number of requester ports (2..8).
- DATA_W, 32, operand and result width.
- ID_W, $clog2(NUM_REQ), width of the requester ID tag.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit is high per cycle.
- req_a  input  NUM_REQ*DATA_W  packed operand A; requester i occupies bits [i*DATA_W +: DATA_W].
- req_b  input  NUM_REQ*DATA_W  packed operand B, same packing as req_a.
- req_sub  input  NUM_REQ  per-requester op select: 0 = A+B, 1 = A-B.
- resp_valid  output  1  response register holds a result.
- resp_ready  input  1  consumer accepts the response.
- resp_data  output  DATA_W  result, modulo 2^DATA_W.
- resp_id  output  ID_W  index of the requester that produced the result.

Behaviour:
- Reset (rst=1 at a clock edge) sets:
  - resp_valid=0, resp_data=0, resp_id=0;
  - round-robin pointer rr_ptr=0.
  - req_ready is combinational; it is all-zero while rst=1.
- Output slot:
  - slot_free = !resp_valid || resp_ready.
  - No grant is made when slot_free=0. All req_ready bits are low, and requesters hold their request, including operands.
- Arbitration, combinational in the same cycle:
  - When slot_free=1, grant the first asserted req_valid bit searching from rr_ptr upward with wrap-around (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...).
  - req_ready[g]=1 for the granted index g only.
  - A transfer occurs on requester g when req_valid[g] && req_ready[g].
- Datapath:
  - The adder sees the granted requester's operands: A + (sub ? ~B : B) + sub, truncated to DATA_W bits. Wrap-around is silent.
- Latency:
  - Result registered at the edge ending the transfer cycle; resp_valid=1 in the next cycle.
  - resp_data = result, resp_id = g.
  - Exactly one cycle from transfer to response.
- Pointer update: on a transfer, rr_ptr <= (g+1) mod NUM_REQ. With no transfer, rr_ptr holds.
- Response register:
  - Transfer and resp_ready in the same cycle: load the new result; resp_valid stays 1. Full throughput is 1 result/cycle.
  - resp_ready=1 with no transfer: resp_valid <= 0; data/id hold their old value.
  - resp_valid=1, resp_ready=0: data and id hold stable.
- No requests while slot_free=1: all req_ready low; rr_ptr unchanged.
- States: the response slot has two states.
  - EMPTY → FULL on a transfer.
  - FULL → FULL on a transfer with resp_ready.
  - FULL → EMPTY on resp_ready with no transfer.
- Reset mid-operation: a pending response is discarded, no req_ready is asserted during the reset cycle, and rr_ptr returns to 0.
- A requester must not drop req_valid or change its operands until it sees req_ready. The block does not check this.

Optional Feature:
- Macro: ADDER_ARBITER_FLAGS_EN.
- Defined: adds output resp_carry (1 bit) and output resp_ovf (1 bit), registered alongside resp_data and cleared on reset.
  - resp_carry is the carry-out of the DATA_W-bit addition. For subtract it equals NOT borrow.
  - resp_ovf is signed overflow: operands of equal sign (B inverted for subtract) producing a result of the opposite sign.
- Undefined: neither port exists; the adder is DATA_W bits wide with no carry-out logic.

Decomposition:
- Package adder_arbiter_pkg holds:
  - localparam DATA_W_DEF=32;
  - typedef enum logic {OP_ADD=1'b0, OP_SUB=1'b1} add_op_e;
  - a function for the round-robin one-hot search.
- Sub-module rr_arbiter (parameter N) is natural and reusable for other shared units. It maps req[N] and ptr to grant one-hot, grant index and any_grant.
- The adder and response register stay in the top module.

Test Plan:
- Single request: requester 2 sends a=0x0000_0010, b=0x0000_0004, sub=0.
  - Required: req_ready[2] same cycle; next cycle resp_valid=1, resp_data=0x14, resp_id=2.
- Wrap and subtract:
  - a=0xFFFF_FFFF, b=1, sub=0 → resp_data=0x0000_0000 (with the flags feature: carry=1, ovf=0).
  - a=0, b=1, sub=1 → 0xFFFF_FFFF.
- Fairness: all 4 requesters hold valid with resp_ready=1 from reset.
  - Grants are 0,1,2,3,0,1 in consecutive cycles; resp_id follows one cycle later with no bubbles.
- Backpressure: fill the slot, then hold resp_ready=0 for 5 cycles with requesters 1 and 3 valid.
  - Required: req_ready all 0; resp_data/resp_id stable.
  - On resp_ready=1 the same cycle grants requester 1 (rr_ptr=1 after a grant to 0).
- Reset mid-stream: assert rst for 1 cycle while resp_valid=1 and requests are pending.
  - Required: next cycle resp_valid=0, req_ready=0; after release, the first grant goes to the lowest valid index from 0.
- Signed overflow (flags feature): a=0x7FFF_FFFF, b=1, sub=0.
  - Required: resp_data=0x8000_0000, ovf=1, carry=0.
